// File: rtl/sha256_padded_engine_if.sv
// Memory port of the SHA-256/224 engine: one synchronous single-port RAM,
// with read data arriving one cycle after the address.
interface sha256_padded_engine_if;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output mem_clk, mem_we, mem_addr, mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_clk, mem_we, mem_addr, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/sha256_padded_engine.sv
// SHA-256 / SHA-224 engine. It pads the message on the fly while reading it from RAM,
// runs one round per cycle, and writes the digest back to the same RAM.
module sha256_padded_engine #(
  parameter int MAX_WORDS = 64,
  parameter int SHA224_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [15:0] num_words,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  output logic        done,
  output logic        err,
  sha256_padded_engine_if.master mem
);

  typedef enum logic [2:0] {IDLE, READ, COMPUTE, UPDATE, WRITE} state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_t      state, next_state;
  logic [6:0]  cnt;
  logic [6:0]  blk, nblk;
  logic        mode_q;
  logic [15:0] n_q, msg_base, out_base;
  logic [31:0] hs [8];
  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] w [16];

  logic        start_ok, sel224, is_last;
  logic [16:0] n_plus2;
  logic [15:0] gidx_rd, gidx_cap;
  logic [3:0]  j_cap;
  logic [6:0]  last_wr;
  logic [31:0] pad_word, t1, t2, w_next;

  assign mem.mem_clk = clk;

  assign start_ok = (num_words != 16'd0) && (num_words <= 16'(MAX_WORDS));
  assign sel224   = (SHA224_EN != 0) && mode;
  assign n_plus2  = {1'b0, num_words} + 17'd2;
  assign is_last  = (blk == nblk - 7'd1);
  assign last_wr  = mode_q ? 7'd6 : 7'd7;

  // A word is requested in READ cycle cnt and captured one cycle later, hence cnt-1.
  assign gidx_rd  = 16'({blk, 4'b0000}) + 16'(cnt);
  assign j_cap    = 4'(cnt - 7'd1);
  assign gidx_cap = 16'({blk, 4'b0000}) + 16'(j_cap);

  always_comb begin
    if (is_last && j_cap == 4'd14)      pad_word = 32'h0;
    else if (is_last && j_cap == 4'd15) pad_word = {11'b0, n_q, 5'b0};
    else if (gidx_cap < n_q)            pad_word = mem.mem_read_data;
    else if (gidx_cap == n_q)           pad_word = 32'h80000000;
    else                                pad_word = 32'h0;
  end

  // w[0] always holds W[t]; the new tail entry is W[t+16].
  assign t1     = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + K[cnt[5:0]] + w[0];
  assign t2     = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
  assign w_next = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && start_ok) next_state = READ;
      READ:    if (cnt == 7'd16) next_state = COMPUTE;
      COMPUTE: if (cnt == 7'd63) next_state = UPDATE;
      UPDATE:  next_state = (blk + 7'd1 < nblk) ? READ : WRITE;
      WRITE:   if (cnt == last_wr) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    done               = 1'b0;
    mem.mem_we         = 1'b0;
    mem.mem_addr       = 16'h0;
    mem.mem_write_data = 32'h0;
    case (state)
      IDLE: done = 1'b1;
      READ: begin
        if (cnt < 7'd16 && gidx_rd < n_q) mem.mem_addr = msg_base + gidx_rd;
      end
      WRITE: begin
        mem.mem_we         = 1'b1;
        mem.mem_addr       = out_base + 16'(cnt);
        mem.mem_write_data = hs[cnt[2:0]];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
      cnt <= 7'd0;
      blk <= 7'd0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 7'd0;
          blk <= 7'd0;
          if (start && start_ok) begin
            mode_q   <= sel224;
            n_q      <= num_words;
            msg_base <= message_addr;
            out_base <= output_addr;
            nblk     <= 7'(n_plus2 >> 4) + 7'd1;
            for (int i = 0; i < 8; i++) hs[i] <= sel224 ? IV224[i] : IV256[i];
          end else if (start) begin
            err <= 1'b1;
          end
        end
        READ: begin
          if (cnt != 7'd0) begin
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= pad_word;
          end
          if (cnt == 7'd16) begin
            cnt <= 7'd0;
            a <= hs[0]; b <= hs[1]; c <= hs[2]; d <= hs[3];
            e <= hs[4]; f <= hs[5]; g <= hs[6]; h <= hs[7];
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        COMPUTE: begin
          h <= g; g <= f; f <= e; e <= d + t1;
          d <= c; c <= b; b <= a; a <= t1 + t2;
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_next;
          cnt <= (cnt == 7'd63) ? 7'd0 : cnt + 7'd1;
        end
        UPDATE: begin
          hs[0] <= hs[0] + a; hs[1] <= hs[1] + b;
          hs[2] <= hs[2] + c; hs[3] <= hs[3] + d;
          hs[4] <= hs[4] + e; hs[5] <= hs[5] + f;
          hs[6] <= hs[6] + g; hs[7] <= hs[7] + h;
          blk <= blk + 7'd1;
          cnt <= 7'd0;
        end
        WRITE: cnt <= cnt + 7'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padded_engine.sv
// Directed bench for sha256_padded_engine: known digests, padding edges, errors,
// held start, address wrap and mid-operation reset, checked against a reference model.
module tb_sha256_padded_engine;

  localparam int MAXW = 64;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] H256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] H224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939, 32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };
  localparam logic [31:0] ABCD256 [8] = '{
    32'h88d4266f, 32'hd4e6338d, 32'h13b845fc, 32'hf289579d, 32'h209c8978, 32'h23b9217d, 32'ha3e16193, 32'h6f031589
  };

  logic        clk, reset, start, mode, done, err, log_clear;
  logic [15:0] num_words, message_addr, output_addr;
  logic [31:0] ram [65536];
  logic [31:0] exp_dig [8];
  logic [15:0] wr_addr_log [16];
  logic [31:0] wr_data_log [16];
  logic [15:0] rd_max = 16'h0;
  int          wr_count = 0;
  int          checks_total = 0;
  int          checks_passed = 0;
  int          cyc;

  sha256_padded_engine_if mem_if ();

  sha256_padded_engine #(.MAX_WORDS(MAXW), .SHA224_EN(1)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .num_words(num_words),
    .message_addr(message_addr), .output_addr(output_addr), .done(done), .err(err),
    .mem(mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_if.mem_read_data <= ram[mem_if.mem_addr];

  // Write log and highest read address since the last accepted start.
  always @(posedge clk) begin
    if (log_clear) begin
      wr_count <= 0;
      rd_max   <= 16'h0;
    end else if (mem_if.mem_we) begin
      if (wr_count < 16) begin
        wr_addr_log[wr_count] <= mem_if.mem_addr;
        wr_data_log[wr_count] <= mem_if.mem_write_data;
      end
      wr_count <= wr_count + 1;
    end else if (!done && mem_if.mem_addr > rd_max) begin
      rd_max <= mem_if.mem_addr;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straightforward whole-message reference: full 64-entry schedule per block.
  task automatic goldenDigest(input int n, input bit m224, input logic [15:0] base);
    logic [31:0] hv [8];
    logic [31:0] ws [64];
    logic [31:0] va, vb, vc, vd, ve, vf, vg, vh, s1, s2;
    int nb, idx;
    nb = (4 * n + 9 + 63) / 64;
    for (int i = 0; i < 8; i++) hv[i] = m224 ? H224[i] : H256[i];
    for (int bk = 0; bk < nb; bk++) begin
      for (int t = 0; t < 16; t++) begin
        idx = bk * 16 + t;
        if (idx < n)                ws[t] = ram[16'(base + 16'(idx))];
        else if (idx == n)          ws[t] = 32'h80000000;
        else if (idx == nb * 16 - 1) ws[t] = 32'(n * 32);
        else                        ws[t] = 32'h0;
      end
      for (int t = 16; t < 64; t++)
        ws[t] = (rotr(ws[t-2], 17) ^ rotr(ws[t-2], 19) ^ (ws[t-2] >> 10)) + ws[t-7]
              + (rotr(ws[t-15], 7) ^ rotr(ws[t-15], 18) ^ (ws[t-15] >> 3)) + ws[t-16];
      va = hv[0]; vb = hv[1]; vc = hv[2]; vd = hv[3];
      ve = hv[4]; vf = hv[5]; vg = hv[6]; vh = hv[7];
      for (int t = 0; t < 64; t++) begin
        s1 = vh + (rotr(ve, 6) ^ rotr(ve, 11) ^ rotr(ve, 25)) + ((ve & vf) ^ (~ve & vg)) + KT[t] + ws[t];
        s2 = (rotr(va, 2) ^ rotr(va, 13) ^ rotr(va, 22)) + ((va & vb) ^ (va & vc) ^ (vb & vc));
        vh = vg; vg = vf; vf = ve; ve = vd + s1;
        vd = vc; vc = vb; vb = va; va = s1 + s2;
      end
      hv[0] += va; hv[1] += vb; hv[2] += vc; hv[3] += vd;
      hv[4] += ve; hv[5] += vf; hv[6] += vg; hv[7] += vh;
    end
    for (int i = 0; i < 8; i++) exp_dig[i] = hv[i];
  endtask

  // Issues an accepted start; unless held, the request inputs are scrambled afterwards.
  task automatic applyStimulus(input bit m, input int n, input logic [15:0] ma, input logic [15:0] oa, input bit hold);
    @(negedge clk);
    mode = m; num_words = 16'(n); message_addr = ma; output_addr = oa;
    start = 1'b1; log_clear = 1'b1;
    @(negedge clk);
    log_clear = 1'b0;
    if (!hold) begin
      start = 1'b0; mode = ~m; num_words = 16'hFFFF;
      message_addr = ma ^ 16'h5555; output_addr = oa ^ 16'h00F0;
    end
  endtask

  task automatic waitDone(input string tag, input bit poke, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (poke && cycles == 3) start = 1'b1;
      if (poke && cycles == 4) start = 1'b0;
    end
    checkOutput({tag, " done"}, 32'(done), 32'd1);
  endtask

  task automatic checkWrites(input string tag, input logic [15:0] oa, input int wn);
    checkOutput({tag, " write count"}, 32'(wr_count), 32'(wn));
    for (int i = 0; i < wn; i++) begin
      checkOutput($sformatf("%s addr%0d", tag, i), 32'(wr_addr_log[i]), 32'(16'(oa + 16'(i))));
      checkOutput($sformatf("%s word%0d", tag, i), wr_data_log[i], exp_dig[i]);
    end
  endtask

  task automatic runCase(input string tag, input bit m, input int n, input logic [15:0] ma,
                         input logic [15:0] oa, input int exp_lat, input bit use_model);
    if (use_model) goldenDigest(n, m, ma);
    applyStimulus(m, n, ma, oa, 1'b0);
    waitDone(tag, 1'b1, cyc);
    checkOutput({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    checkWrites(tag, oa, m ? 7 : 8);
  endtask

  task automatic errCase(input string tag, input int n);
    @(negedge clk);
    mode = 1'b0; num_words = 16'(n); message_addr = 16'h0; output_addr = 16'h0600;
    start = 1'b1; log_clear = 1'b1;
    @(negedge clk);
    log_clear = 1'b0; start = 1'b0;
    checkOutput({tag, " err pulse"}, 32'(err), 32'd1);
    checkOutput({tag, " done held"}, 32'(done), 32'd1);
    @(negedge clk);
    checkOutput({tag, " err cleared"}, 32'(err), 32'd0);
    checkOutput({tag, " done still"}, 32'(done), 32'd1);
    checkOutput({tag, " no access"}, 32'(mem_if.mem_addr), 32'd0);
    checkOutput({tag, " no writes"}, 32'(wr_count), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; num_words = 16'h0;
    message_addr = 16'h0; output_addr = 16'h0; log_clear = 1'b0;
    for (int i = 0; i < 65536; i++) ram[i] = 32'h0;
    for (int i = 0; i < 64; i++) ram[i] = 32'h01234567 ^ (32'(i) * 32'h9E3779B9);
    ram[16'hFFFE] = 32'hCAFEF00D;
    ram[16'hFFFF] = 32'h12345678;
    ram[16'h0200] = 32'h61626364;

    repeat (3) @(negedge clk);
    checkOutput("reset done", 32'(done), 32'd1);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("reset we", 32'(mem_if.mem_we), 32'd0);
    checkOutput("reset addr", 32'(mem_if.mem_addr), 32'd0);
    checkOutput("reset wdata", mem_if.mem_write_data, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) exp_dig[i] = ABCD256[i];
    runCase("abcd256", 1'b0, 1, 16'h0200, 16'h0300, 90, 1'b0);

    runCase("n20", 1'b0, 20, 16'h0000, 16'h0100, 172, 1'b1);
    checkOutput("n20 max read addr", 32'(rd_max), 32'd19);
    runCase("n13", 1'b0, 13, 16'h0000, 16'h0300, 90, 1'b1);
    runCase("n14", 1'b0, 14, 16'h0000, 16'h0300, 172, 1'b1);
    runCase("n16", 1'b0, 16, 16'h0000, 16'h0300, 172, 1'b1);
    runCase("abcd224", 1'b1, 1, 16'h0200, 16'h0300, 89, 1'b1);
    runCase("n20 sha224", 1'b1, 20, 16'h0000, 16'h0300, 171, 1'b1);
    runCase("wrap", 1'b0, 4, 16'hFFFE, 16'hFFFC, 90, 1'b1);
    runCase("nmax", 1'b0, MAXW, 16'h0000, 16'h0300, 418, 1'b1);

    errCase("n0", 0);
    errCase("nmax+1", MAXW + 1);

    // Start held through completion relaunches on the single IDLE cycle.
    for (int i = 0; i < 8; i++) exp_dig[i] = ABCD256[i];
    applyStimulus(1'b0, 1, 16'h0200, 16'h0300, 1'b1);
    waitDone("held first", 1'b0, cyc);
    checkOutput("held first latency", 32'(cyc), 32'd90);
    checkWrites("held first", 16'h0300, 8);
    log_clear = 1'b1;
    @(negedge clk);
    checkOutput("held relaunch busy", 32'(done), 32'd0);
    log_clear = 1'b0; start = 1'b0;
    waitDone("held second", 1'b0, cyc);
    checkOutput("held second latency", 32'(cyc), 32'd90);
    checkWrites("held second", 16'h0300, 8);

    // Reset during the second block's rounds, then a clean run.
    applyStimulus(1'b0, 20, 16'h0000, 16'h0400, 1'b0);
    repeat (120) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort done", 32'(done), 32'd1);
    checkOutput("abort we", 32'(mem_if.mem_we), 32'd0);
    repeat (200) @(negedge clk);
    checkOutput("abort no writes", 32'(wr_count), 32'd0);
    checkOutput("abort idle", 32'(done), 32'd1);
    for (int i = 0; i < 8; i++) exp_dig[i] = ABCD256[i];
    runCase("after abort", 1'b0, 1, 16'h0200, 16'h0500, 90, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/sha256_padded_engine.md
SHA256_PADDED_ENGINE -- requirements
Module: sha256_padded_engine

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 64: largest accepted message length in 32-bit words (1..1024).
REQ-002 SHALL have parameter SHA224_EN, default 1: 1 = mode input honoured; 0 = mode ignored, always SHA-256.
REQ-003 SHALL have port clk  in  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have port start  in  1: request; sampled only in IDLE.
REQ-006 SHALL have port mode  in  1: 0 = SHA-256, 1 = SHA-224; captured at start.
REQ-007 SHALL have port num_words  in  16: message length N in words; captured at start.
REQ-008 SHALL have ports message_addr and output_addr  in  16 each: word base addresses; captured at start.
REQ-009 SHALL have port done  out  1: high only in IDLE.
REQ-010 SHALL have port err  out  1: one-cycle pulse when a start is rejected.
REQ-011 SHALL have ports mem_clk  out  1 (= clk), mem_we  out  1, mem_addr  out  16, mem_write_data  out  32.
REQ-012 SHALL have port mem_read_data  in  32: synchronous RAM; data for the address presented in cycle n is valid in cycle n+1.

Function
REQ-013 SHALL implement states IDLE, READ, COMPUTE, UPDATE, WRITE.
REQ-014 In IDLE with start=1 and 1<=N<=MAX_WORDS, SHALL capture inputs, load h0..h7 with the IV for the selected mode, and enter READ.
REQ-015 In IDLE with start=1 and N=0 or N>MAX_WORDS, SHALL pulse err for one cycle and remain in IDLE.
REQ-016 SHALL compute the block count as B = floor((N+2)/16)+1.
REQ-017 READ SHALL last exactly 17 cycles per block.
REQ-018 During READ, mem_addr SHALL equal message_addr+g only for global word index g<N; mem_we SHALL be 0.
REQ-019 The padded block word at global index g SHALL be mem_read_data if g<N, 32'h80000000 if g=N, and 0 otherwise.
REQ-020 In the last block, words 14 and 15 SHALL be overridden with 0 and N*32 respectively; padding words SHALL NOT cause memory reads.
REQ-021 At READ exit, SHALL load a..h from h0..h7.
REQ-022 COMPUTE SHALL execute one SHA-256 round per cycle for t = 0..63, exactly 64 cycles, using a 16-entry rolling W schedule.
REQ-023 The schedule SHALL use W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] for t>=16; all additions mod 2^32.
REQ-024 Round logic SHALL use bitwise (not logical) AND/NOT for Ch and Maj.
REQ-025 UPDATE SHALL last 1 cycle: hk <= hk + reg_k.
REQ-026 From UPDATE, SHALL go to READ if blocks remain, else to WRITE.
REQ-027 WRITE SHALL last Wn cycles, Wn = 8 (SHA-256) or 7 (SHA-224).
REQ-028 In WRITE cycle k, SHALL drive mem_we=1, mem_addr=output_addr+k, mem_write_data=hk; it SHALL then return to IDLE.
REQ-029 Latency from the start-accepting edge to done=1 SHALL be B*82 + Wn cycles.
REQ-030 start, mode, num_words and address changes while not in IDLE SHALL be ignored.
REQ-031 start held high through the return to IDLE SHALL launch a new operation on the first IDLE cycle; done is high for that one cycle.
REQ-032 Address arithmetic SHALL wrap mod 2^16.

Reset
REQ-033 On reset, SHALL enter IDLE with done=1, err=0, mem_we=0, mem_addr=0, and mem_write_data=0.
REQ-034 Reset asserted mid-operation SHALL abort on that edge; no further memory writes SHALL occur and partial results SHALL be discarded.

Verification
REQ-035 SHA-256, N=1, mem[message_addr]=32'h61626364 ("abcd") -> output words 88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589; done after 90 cycles.
REQ-036 SHA-256, N=20, message_addr=0, output_addr=16'h0100 -> B=2; digest matches golden model; exactly 8 writes to 0x0100..0x0107; latency 172 cycles; no read above address 19.
REQ-037 Padding boundaries: N=13 -> B=1, latency 90. N=14 -> B=2, latency 172. N=16 -> B=2. All digests match golden model.
REQ-038 SHA-224, N=1 "abcd" -> 7 writes only; output_addr+7 untouched; latency 89 cycles; digest matches golden model.
REQ-039 start with N=0, then with N=MAX_WORDS+1 -> err pulses 1 cycle each; done stays 1; no memory access.
REQ-040 Reset asserted in COMPUTE of block 2 -> IDLE next cycle, mem_we stays 0. A subsequent valid start yields a correct digest.
